// File: rtl/rxpybuf.sv
// rxpybuf: receive payload word buffer; captures decoded payload words into a bank, commits it with header/CRC, serves host reads.
// Define RXPYBUF_PINGPONG_EN for two banks (receive while host reads); default build has a single bank.
module rxpybuf #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_6M,
  input  logic          rstz,
  input  logic          dec_py_period,
  input  logic          dec_py_endp,
  input  logic [31:0]   rxpydin,
  input  logic [7:0]    rxpyadr,
  input  logic          rxpydin_valid_p_wr,
  input  logic          dec_crcgood,
  input  logic [1:0]    dec_LLID,
  input  logic          dec_pyFLOW,
  input  logic [9:0]    dec_pylenByte,
  input  logic          rx_abort,
  input  logic          host_rd_en,
  input  logic [AW-1:0] host_rd_adr,
  input  logic          host_release_p,
  output logic [31:0]   host_rd_data,
  output logic          rx_rdy,
  output logic [9:0]    rx_len_byte,
  output logic [1:0]    rx_llid,
  output logic          rx_flow,
  output logic          rx_crcgood,
  output logic [AW:0]   rx_wordcnt,
  output logic          rx_ovfl,
  output logic          rx_drop_p
);

`ifdef RXPYBUF_PINGPONG_EN
  localparam int   NB        = 2;
  localparam logic BANK_FLIP = 1'b1;
  localparam int   MW        = AW + 1;
`else
  localparam int   NB        = 1;
  localparam logic BANK_FLIP = 1'b0;
  localparam int   MW        = AW;
`endif
  localparam logic [8:0] DEPTH_C  = 9'(DEPTH);
  localparam logic [AW:0] WCNT_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_FILL  = 2'd1,
    W_FLUSH = 2'd2,
    W_DROP  = 2'd3
  } wstate_t;

  wstate_t       state_r, state_nx_s;
  logic          period_d1_r;
  logic          wr_bank_r, wr_bank_nx_s;
  logic          rd_bank_r, rd_bank_nx_s;
  logic [NB-1:0] full_r, full_nx_s;

  logic [9:0]    len_r  [NB];
  logic [1:0]    llid_r [NB];
  logic          flow_r [NB];
  logic          crc_r  [NB];
  logic [AW:0]   wcnt_r [NB];
  logic          ovfl_r [NB];
  logic [9:0]    len_nx_s  [NB];
  logic [1:0]    llid_nx_s [NB];
  logic          flow_nx_s [NB];
  logic          crc_nx_s  [NB];
  logic [AW:0]   wcnt_nx_s [NB];
  logic          ovfl_nx_s [NB];

  logic          drop_nx_s;
  logic          start_s;
  logic          adr_ok_s;
  logic          mem_we_s;
  logic [MW-1:0] mem_wadr_s;
  logic [MW-1:0] mem_radr_s;
  logic [31:0]   mem_r [NB*DEPTH];

  logic [31:0]   rd_data_r;
  logic          rx_rdy_r;
  logic [9:0]    rx_len_r;
  logic [1:0]    rx_llid_r;
  logic          rx_flow_r;
  logic          rx_crc_r;
  logic [AW:0]   rx_wcnt_r;
  logic          rx_ovfl_r;
  logic          rx_drop_r;

  assign start_s  = dec_py_period & ~period_d1_r;
  assign adr_ok_s = ({1'b0, rxpyadr} < DEPTH_C);

`ifdef RXPYBUF_PINGPONG_EN
  assign mem_wadr_s = {wr_bank_r, rxpyadr[AW-1:0]};
  assign mem_radr_s = {rd_bank_r, host_rd_adr};
`else
  assign mem_wadr_s = rxpyadr[AW-1:0];
  assign mem_radr_s = host_rd_adr;
`endif

  // Write FSM, bank bookkeeping and host release: next-state computation
  always_comb begin
    state_nx_s   = state_r;
    wr_bank_nx_s = wr_bank_r;
    rd_bank_nx_s = rd_bank_r;
    full_nx_s    = full_r;
    len_nx_s     = len_r;
    llid_nx_s    = llid_r;
    flow_nx_s    = flow_r;
    crc_nx_s     = crc_r;
    wcnt_nx_s    = wcnt_r;
    ovfl_nx_s    = ovfl_r;
    drop_nx_s    = 1'b0;
    mem_we_s     = 1'b0;

    if (host_release_p && full_r[rd_bank_r]) begin
      full_nx_s[rd_bank_r] = 1'b0;
      rd_bank_nx_s         = rd_bank_r ^ BANK_FLIP;
    end else begin
      rd_bank_nx_s = rd_bank_r;
    end

    // Abort wins over every other write-side event; the bank is never committed
    if (rx_abort) begin
      state_nx_s = W_IDLE;
    end else begin
      case (state_r)
        W_IDLE: begin
          if (start_s && !full_r[wr_bank_r]) begin
            state_nx_s           = W_FILL;
            wcnt_nx_s[wr_bank_r] = '0;
            ovfl_nx_s[wr_bank_r] = 1'b0;
          end else if (start_s) begin
            state_nx_s = W_DROP;
            drop_nx_s  = 1'b1;
          end else begin
            state_nx_s = W_IDLE;
          end
        end
        W_FILL: begin
          if (rxpydin_valid_p_wr && adr_ok_s) begin
            mem_we_s             = 1'b1;
            wcnt_nx_s[wr_bank_r] = wcnt_r[wr_bank_r] + WCNT_ONE;
          end else if (rxpydin_valid_p_wr) begin
            ovfl_nx_s[wr_bank_r] = 1'b1;
          end else begin
            mem_we_s = 1'b0;
          end
          if (dec_py_endp) begin
            state_nx_s           = W_FLUSH;
            len_nx_s[wr_bank_r]  = dec_pylenByte;
            llid_nx_s[wr_bank_r] = dec_LLID;
            flow_nx_s[wr_bank_r] = dec_pyFLOW;
          end else begin
            state_nx_s = W_FILL;
          end
        end
        W_FLUSH: begin
          if (rxpydin_valid_p_wr) begin
            if (adr_ok_s) begin
              mem_we_s             = 1'b1;
              wcnt_nx_s[wr_bank_r] = wcnt_r[wr_bank_r] + WCNT_ONE;
            end else begin
              ovfl_nx_s[wr_bank_r] = 1'b1;
            end
            crc_nx_s[wr_bank_r]  = dec_crcgood;
            full_nx_s[wr_bank_r] = 1'b1;
            wr_bank_nx_s         = wr_bank_r ^ BANK_FLIP;
            state_nx_s           = W_IDLE;
          end else begin
            state_nx_s = W_FLUSH;
          end
        end
        W_DROP: begin
          if (dec_py_endp) begin
            state_nx_s = W_IDLE;
          end else begin
            state_nx_s = W_DROP;
          end
        end
        default: state_nx_s = W_IDLE;
      endcase
    end
  end

  // State, per-bank header latches and registered status outputs
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_r     <= W_IDLE;
      period_d1_r <= 1'b0;
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      full_r      <= '0;
      for (int b = 0; b < NB; b++) begin
        len_r[b]  <= 10'd0;
        llid_r[b] <= 2'd0;
        flow_r[b] <= 1'b0;
        crc_r[b]  <= 1'b0;
        wcnt_r[b] <= '0;
        ovfl_r[b] <= 1'b0;
      end
      rx_rdy_r  <= 1'b0;
      rx_len_r  <= 10'd0;
      rx_llid_r <= 2'd0;
      rx_flow_r <= 1'b0;
      rx_crc_r  <= 1'b0;
      rx_wcnt_r <= '0;
      rx_ovfl_r <= 1'b0;
      rx_drop_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      period_d1_r <= dec_py_period;
      wr_bank_r   <= wr_bank_nx_s;
      rd_bank_r   <= rd_bank_nx_s;
      full_r      <= full_nx_s;
      len_r       <= len_nx_s;
      llid_r      <= llid_nx_s;
      flow_r      <= flow_nx_s;
      crc_r       <= crc_nx_s;
      wcnt_r      <= wcnt_nx_s;
      ovfl_r      <= ovfl_nx_s;
      rx_rdy_r    <= full_nx_s[rd_bank_nx_s];
      rx_len_r    <= len_nx_s[rd_bank_nx_s];
      rx_llid_r   <= llid_nx_s[rd_bank_nx_s];
      rx_flow_r   <= flow_nx_s[rd_bank_nx_s];
      rx_crc_r    <= crc_nx_s[rd_bank_nx_s];
      rx_wcnt_r   <= wcnt_nx_s[rd_bank_nx_s];
      rx_ovfl_r   <= ovfl_nx_s[rd_bank_nx_s];
      rx_drop_r   <= drop_nx_s;
    end
  end

  // Payload word storage; contents survive reset
  always_ff @(posedge clk_6M) begin
    if (mem_we_s) begin
      mem_r[mem_wadr_s] <= rxpydin;
    end
  end

  // Registered host read port, holds last value when idle
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      rd_data_r <= 32'd0;
    end else if (host_rd_en) begin
      rd_data_r <= mem_r[mem_radr_s];
    end
  end

  assign host_rd_data = rd_data_r;
  assign rx_rdy       = rx_rdy_r;
  assign rx_len_byte  = rx_len_r;
  assign rx_llid      = rx_llid_r;
  assign rx_flow      = rx_flow_r;
  assign rx_crcgood   = rx_crc_r;
  assign rx_wordcnt   = rx_wcnt_r;
  assign rx_ovfl      = rx_ovfl_r;
  assign rx_drop_p    = rx_drop_r;

endmodule
